// File: rtl/kbd_pkg.sv
// Shared constants, parser state encoding and key-event record for the
// PS/2 key event queue.
package kbd_pkg;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_PAUSE  = 8'hE1;
   localparam logic [7:0] PS2_BAT    = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_ERR0   = 8'h00;
   localparam logic [7:0] PS2_ERR1   = 8'hFF;

   // Bytes that follow the leading E1 of a Pause sequence.
   localparam logic [2:0] PAUSE_TAIL = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PREFIX = 2'd1,
      ST_PAUSE  = 2'd2
   } parse_state_e;

   typedef struct packed {
      logic       ext;
      logic       make;
      logic [7:0] code;
   } key_event_t;

   // Controller error bytes; never a key code, even after a prefix.
   function automatic logic is_err_byte(input logic [7:0] b);
      return (b == PS2_ERR0) || (b == PS2_ERR1);
   endfunction

   // Controller status/handshake bytes, only meaningful outside a sequence.
   function automatic logic is_status_byte(input logic [7:0] b);
      return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_RESEND);
   endfunction

endpackage

// File: rtl/kbd_event_queue_if.sv
// Byte-in / event-out bundle of the key event queue.
interface kbd_event_queue_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          ps2_key_en;
   logic [7:0]    ps2_key_data;
   logic [7:0]    keycode;
   logic          ext;
   logic          make;
   logic          keycode_valid;
   logic          keycode_ready;
   logic [CW-1:0] count;
   logic          overflow;
   logic          clr_overflow;

   modport slave (
      input  ps2_key_en, ps2_key_data, keycode_ready, clr_overflow,
      output keycode, ext, make, keycode_valid, count, overflow
   );

   modport master (
      output ps2_key_en, ps2_key_data, keycode_ready, clr_overflow,
      input  keycode, ext, make, keycode_valid, count, overflow
   );
endinterface

// File: rtl/kbd_event_fifo.sv
// Generic synchronous FIFO. Head entry is read straight from the storage
// flops; push into a full FIFO is accepted only when a pop frees a slot.
module kbd_event_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   // Qualify requests and compute next pointers, count and storage.
   always_comb begin
      pop_ok   = pop && (count_q != '0);
      push_ok  = push && ((count_q != FULL_CNT) || pop_ok);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage, pointers and occupancy registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign count   = count_q;

endmodule

// File: rtl/kbd_event_queue.sv
// PS/2 scan-byte parser feeding a key-event FIFO with a valid/ready pop port.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for the first byte of a key sequence
//   ST_PREFIX | E0 and/or F0 seen; next ordinary byte completes the event
//   ST_PAUSE  | inside the E1 Pause sequence, counting its tail bytes
module kbd_event_queue
   import kbd_pkg::*;
#(
   parameter int DEPTH           = 4,
   parameter int SUPPRESS_REPEAT = 1,
   parameter int EMIT_PAUSE      = 1
) (
   input logic              clk,
   input logic              reset_n,
   kbd_event_queue_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   parse_state_e state_q, state_d;
   logic         ext_f_q, ext_f_d;
   logic         brk_f_q, brk_f_d;
   logic [2:0]   pause_cnt_q, pause_cnt_d;
   logic         last_valid_q, last_valid_d;
   logic [8:0]   last_key_q, last_key_d;
   logic         overflow_q, overflow_d;

   logic         cand_valid;
   logic         cand_pause;
   key_event_t   cand_evt;
   logic         push;
   logic         drop;
   key_event_t   head;
   logic         fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [7:0]   b;

   assign b = bus.ps2_key_data;

   // Parser and filter state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         ext_f_q      <= 1'b0;
         brk_f_q      <= 1'b0;
         pause_cnt_q  <= '0;
         last_valid_q <= 1'b0;
         last_key_q   <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         ext_f_q      <= ext_f_d;
         brk_f_q      <= brk_f_d;
         pause_cnt_q  <= pause_cnt_d;
         last_valid_q <= last_valid_d;
         last_key_q   <= last_key_d;
         overflow_q   <= overflow_d;
      end
   end

   // Next parser state, prefix flags and Pause tail counter.
   always_comb begin
      state_d     = state_q;
      ext_f_d     = ext_f_q;
      brk_f_d     = brk_f_q;
      pause_cnt_d = pause_cnt_q;
      if (bus.ps2_key_en) begin
         case (state_q)
            ST_IDLE: begin
               if (b == PS2_EXT) begin
                  ext_f_d = 1'b1;
                  state_d = ST_PREFIX;
               end else if (b == PS2_BRK) begin
                  brk_f_d = 1'b1;
                  state_d = ST_PREFIX;
               end else if (b == PS2_PAUSE) begin
                  pause_cnt_d = PAUSE_TAIL;
                  state_d     = ST_PAUSE;
               end
            end
            ST_PREFIX: begin
               if (b == PS2_EXT) begin
                  ext_f_d = 1'b1;
               end else if (b == PS2_BRK) begin
                  brk_f_d = 1'b1;
               end else begin
                  ext_f_d = 1'b0;
                  brk_f_d = 1'b0;
                  if (b == PS2_PAUSE) begin
                     pause_cnt_d = PAUSE_TAIL;
                     state_d     = ST_PAUSE;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_PAUSE: begin
               pause_cnt_d = pause_cnt_q - 3'd1;
               if (pause_cnt_q <= 3'd1) state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
               ext_f_d = 1'b0;
               brk_f_d = 1'b0;
            end
         endcase
      end
   end

   // Candidate event produced by the current byte.
   always_comb begin
      cand_valid = 1'b0;
      cand_pause = 1'b0;
      cand_evt   = '{ext: 1'b0, make: 1'b1, code: b};
      if (bus.ps2_key_en) begin
         case (state_q)
            ST_IDLE: begin
               cand_valid = (b != PS2_EXT) && (b != PS2_BRK) && (b != PS2_PAUSE) &&
                            !is_err_byte(b) && !is_status_byte(b);
            end
            ST_PREFIX: begin
               cand_valid = (b != PS2_EXT) && (b != PS2_BRK) && (b != PS2_PAUSE) &&
                            !is_err_byte(b);
               cand_evt   = '{ext: ext_f_q, make: ~brk_f_q, code: b};
            end
            ST_PAUSE: begin
               cand_valid = (pause_cnt_q <= 3'd1) && (EMIT_PAUSE != 0);
               cand_pause = 1'b1;
               cand_evt   = '{ext: 1'b1, make: 1'b1, code: PS2_PAUSE};
            end
            default: cand_valid = 1'b0;
         endcase
      end
   end

   // Repeat suppression: track the held key and decide whether to push.
   always_comb begin
      push         = 1'b0;
      last_valid_d = last_valid_q;
      last_key_d   = last_key_q;
      if (cand_valid) begin
         if (cand_pause) begin
            push = 1'b1;
         end else if (cand_evt.make) begin
            if ((SUPPRESS_REPEAT != 0) && last_valid_q &&
                ({cand_evt.ext, cand_evt.code} == last_key_q)) begin
               push = 1'b0;
            end else begin
               push         = 1'b1;
               last_valid_d = 1'b1;
               last_key_d   = {cand_evt.ext, cand_evt.code};
            end
         end else begin
            push = 1'b1;
            if (last_valid_q && ({cand_evt.ext, cand_evt.code} == last_key_q))
               last_valid_d = 1'b0;
         end
      end
   end

   // Sticky overflow; a full FIFO only loses the push when nothing is popped.
   always_comb begin
      drop       = push && fifo_full && !bus.keycode_ready;
      overflow_d = (overflow_q && !bus.clr_overflow) || drop;
   end

   kbd_event_fifo #(
      .WIDTH ($bits(key_event_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .wr_data (cand_evt),
      .pop     (bus.keycode_ready && !fifo_empty),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign bus.keycode       = head.code;
   assign bus.ext           = head.ext;
   assign bus.make          = head.make;
   assign bus.keycode_valid = !fifo_empty;
   assign bus.count         = fifo_count;
   assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_kbd_event_queue.sv
// Directed bench: default instance (DEPTH 4, suppress, emit pause) and a
// second instance (DEPTH 8, no suppression, silent pause) share the byte stream.
module tb_kbd_event_queue;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   kbd_event_queue_if #(.DEPTH(4)) if0 ();
   kbd_event_queue_if #(.DEPTH(8)) if1 ();

   kbd_event_queue #(.DEPTH(4), .SUPPRESS_REPEAT(1), .EMIT_PAUSE(1)) u_dut0 (
      .clk (clk), .reset_n (reset_n), .bus (if0.slave)
   );
   kbd_event_queue #(.DEPTH(8), .SUPPRESS_REPEAT(0), .EMIT_PAUSE(0)) u_dut1 (
      .clk (clk), .reset_n (reset_n), .bus (if1.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] head0();
      return {22'd0, if0.ext, if0.make, if0.keycode};
   endfunction

   task automatic send_byte(input logic [7:0] v);
      @(negedge clk);
      if0.ps2_key_en = 1'b1; if0.ps2_key_data = v;
      if1.ps2_key_en = 1'b1; if1.ps2_key_data = v;
      @(negedge clk);
      if0.ps2_key_en = 1'b0;
      if1.ps2_key_en = 1'b0;
   endtask

   task automatic pop0();
      @(negedge clk); if0.keycode_ready = 1'b1;
      @(negedge clk); if0.keycode_ready = 1'b0;
   endtask

   task automatic pop1();
      @(negedge clk); if1.keycode_ready = 1'b1;
      @(negedge clk); if1.keycode_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset_n = 1'b0;
      #10 reset_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int makes;
      logic [7:0] fill [4];
      logic [7:0] pause_seq [8];
      fill = '{8'h15, 8'h1D, 8'h24, 8'h2D};
      pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

      if0.ps2_key_en = 0; if0.ps2_key_data = 0; if0.keycode_ready = 0; if0.clr_overflow = 0;
      if1.ps2_key_en = 0; if1.ps2_key_data = 0; if1.keycode_ready = 0; if1.clr_overflow = 0;
      #23 reset_n = 1'b1;

      // reset state
      @(negedge clk);
      check("rst_valid", if0.keycode_valid, 0);
      check("rst_count", if0.count, 0);
      check("rst_ovf", if0.overflow, 0);
      check("rst_head", head0(), 0);

      // single make, one-cycle latency, then pop
      send_byte(8'h1C);
      check("mk_head", head0(), 10'h11C);
      check("mk_valid", if0.keycode_valid, 1);
      check("mk_count", if0.count, 1);
      pop0();
      check("mk_pop_valid", if0.keycode_valid, 0);

      // junk byte dropped, then extended break
      do_reset();
      send_byte(8'hAA);
      check("junk_count", if0.count, 0);
      send_byte(8'hE0);
      send_byte(8'hF0);
      check("pfx_pending", if0.count, 0);
      send_byte(8'h74);
      check("ebrk_count", if0.count, 1);
      check("ebrk_head", head0(), 10'h274);

      // typematic repeat suppression
      do_reset();
      send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
      send_byte(8'hF0); send_byte(8'h1C); send_byte(8'h1C);
      check("rep_count0", if0.count, 3);
      check("rep_count1", if1.count, 5);
      check("rep_e0", head0(), 10'h11C); pop0();
      check("rep_e1", head0(), 10'h01C); pop0();
      check("rep_e2", head0(), 10'h11C); pop0();
      check("rep_empty", if0.keycode_valid, 0);
      makes = 0;
      for (int i = 0; i < 5; i++) begin
         makes += int'(if1.make);
         pop1();
      end
      check("rep_makes1", makes, 4);
      check("rep_empty1", if1.count, 0);

      // Pause sequence collapses to one event (or nothing)
      do_reset();
      for (int i = 0; i < 7; i++) send_byte(pause_seq[i]);
      check("pause_partial", if0.count, 0);
      send_byte(pause_seq[7]);
      check("pause_count0", if0.count, 1);
      check("pause_head", head0(), 10'h3E1);
      check("pause_count1", if1.count, 0);

      // fill to full, overflow, push+pop while full, clear
      do_reset();
      for (int i = 0; i < 4; i++) send_byte(fill[i]);
      check("full_count", if0.count, 4);
      check("full_noovf", if0.overflow, 0);
      send_byte(8'h2C);
      check("ovf_count", if0.count, 4);
      check("ovf_set", if0.overflow, 1);
      check("ovf_head", head0(), 10'h115);
      @(negedge clk);
      if0.keycode_ready = 1'b1;
      if0.ps2_key_en = 1'b1; if0.ps2_key_data = 8'h36;
      if1.ps2_key_en = 1'b1; if1.ps2_key_data = 8'h36;
      @(negedge clk);
      if0.keycode_ready = 1'b0;
      if0.ps2_key_en = 1'b0; if1.ps2_key_en = 1'b0;
      check("pp_count", if0.count, 4);
      check("pp_ovf", if0.overflow, 1);
      check("pp_head", head0(), 10'h11D);
      @(negedge clk); if0.clr_overflow = 1'b1;
      @(negedge clk); if0.clr_overflow = 1'b0;
      check("clr_ovf", if0.overflow, 0);
      @(negedge clk);
      if0.clr_overflow = 1'b1;
      if0.ps2_key_en = 1'b1; if0.ps2_key_data = 8'h3C;
      if1.ps2_key_en = 1'b1; if1.ps2_key_data = 8'h3C;
      @(negedge clk);
      if0.clr_overflow = 1'b0;
      if0.ps2_key_en = 1'b0; if1.ps2_key_en = 1'b0;
      check("set_wins", if0.overflow, 1);
      @(negedge clk); if0.clr_overflow = 1'b1;
      @(negedge clk); if0.clr_overflow = 1'b0;
      check("clr_ovf2", if0.overflow, 0);
      check("drain_e0", head0(), 10'h11D); pop0();
      check("drain_e1", head0(), 10'h124); pop0();
      check("drain_e2", head0(), 10'h12D); pop0();
      check("drain_e3", head0(), 10'h136); pop0();
      check("drain_empty", if0.count, 0);

      // reset in the middle of a prefix
      do_reset();
      send_byte(8'hE0);
      do_reset();
      check("midrst_count", if0.count, 0);
      send_byte(8'h74);
      check("midrst_count1", if0.count, 1);
      check("midrst_head0", head0(), 10'h174);
      check("midrst_head1", {if1.ext, if1.make, if1.keycode}, 10'h174);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/kbd_event_queue.md
Name: kbd_event_queue

Overview:
Parametrised successor to the single-register keycode recognizer. It parses the raw PS/2 byte stream into {ext, make, code} key events and buffers them in a DEPTH-entry FIFO with a valid/ready pop handshake, so the game processor never misses a key while it is busy drawing. Over the old recognizer it adds Pause-sequence collapsing, optional typematic-repeat suppression, dropping of controller/status bytes, and a sticky overflow flag. It sits between the PS/2 byte receiver and the processor's key inputs at system level.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
SUPPRESS_REPEAT, 1, when 1, drop a repeated make of the currently held key
EMIT_PAUSE, 1, when 1, a complete Pause sequence yields one event {1,1,8'hE1}; when 0 it is discarded silently

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ps2_key_en  in  1  one-cycle strobe: ps2_key_data holds a received byte
ps2_key_data  in  8  received scan byte
keycode  out  8  code of the head event
ext  out  1  head event had an E0 prefix (or is Pause)
make  out  1  1 = press, 0 = release (head event)
keycode_valid  out  1  FIFO non-empty
keycode_ready  in  1  consumer pops the head when keycode_valid && keycode_ready
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky; set when an event is dropped because the FIFO is full
clr_overflow  in  1  synchronous clear of overflow; a same-cycle set wins

Behaviour:
- Clock and reset: one clock. reset_n is asynchronous and active-low.
- Reset values: parser in IDLE, ext_f/brk_f = 0, pause_cnt = 0, last_valid = 0, FIFO empty, count = 0, keycode_valid = 0, keycode/ext/make = 0, overflow = 0.
- Reset asserted mid-sequence abandons any partial prefix or Pause sequence.
- Bytes are examined only in cycles where ps2_key_en = 1.
- Parser FSM states: IDLE, PREFIX, PAUSE.
  - IDLE, byte E0: set ext_f, go to PREFIX.
  - IDLE, byte F0: set brk_f, go to PREFIX.
  - IDLE, byte E1: pause_cnt = 7, go to PAUSE.
  - IDLE, bytes AA, FA, FE, 00, FF: dropped, stay in IDLE.
  - IDLE, any other byte: candidate event {0, 1, byte}.
  - PREFIX, byte E0 or F0: set the matching flag, stay in PREFIX.
  - PREFIX, byte E1: clear flags, go to PAUSE with pause_cnt = 7.
  - PREFIX, byte 00 or FF: clear flags, go to IDLE, no event.
  - PREFIX, any other byte: candidate event {ext_f, ~brk_f, byte}; clear flags; go to IDLE.
  - PAUSE: each byte decrements pause_cnt. The byte that brings pause_cnt to 0 returns the FSM to IDLE and, if EMIT_PAUSE, produces candidate event {1, 1, E1}. The Pause event bypasses repeat suppression.
- Repeat suppression (SUPPRESS_REPEAT = 1):
  - State registers: last_valid and last_key = {ext, code}.
  - A make whose {ext, code} equals last_key while last_valid = 1 is dropped.
  - Any other make is pushed and loads last_key, setting last_valid.
  - A break matching last_key clears last_valid. Breaks are always pushed.
- Push and latency: a candidate produced from a byte in cycle N is written at the end of cycle N. If the FIFO was empty, keycode_valid = 1 in cycle N+1. The keycode/ext/make outputs always show the head entry and are registered, not combinational from ps2_key_data.
- Pop: occurs when keycode_valid && keycode_ready. The next entry is visible in the following cycle.
- Simultaneous push and pop: allowed at any occupancy, including full (count unchanged, no overflow) and empty (no effect for the pop, since valid = 0).
- Full: a push without a pop is dropped, FIFO contents are unchanged, and overflow is set.
- Pointers wrap modulo DEPTH. count is exact from 0 to DEPTH.

Decomposition:
- Package kbd_pkg holds:
  - byte constants PS2_EXT = E0, PS2_BRK = F0, PS2_PAUSE = E1, PS2_BAT = AA, PS2_ACK = FA, PS2_RESEND = FE, PS2_ERR0 = 00, PS2_ERR1 = FF
  - PAUSE_TAIL = 7
  - parser state enum
  - 10-bit key-event struct {ext, make, code[7:0]}
- One sub-module: kbd_event_fifo, a generic synchronous FIFO with parameters WIDTH and DEPTH, push/pop/full/empty/count, and the same clk/reset_n.

Test Plan:
- Byte 1C, keycode_ready = 0: one cycle later keycode = 1C, ext = 0, make = 1, keycode_valid = 1, count = 1. Pop: keycode_valid = 0 next cycle.
- E0, F0, 74 on three strobes: exactly one event {ext = 1, make = 0, 74}. A junk byte AA before it produces no event.
- SUPPRESS_REPEAT = 1, bytes 1C 1C 1C F0 1C 1C: events {0,1,1C}, {0,0,1C}, {0,1,1C}, count = 3. With SUPPRESS_REPEAT = 0 the same stimulus gives count = 5, of which 4 are make events.
- Pause sequence E1 14 77 E1 F0 14 F0 77: a single event {1,1,E1} after the 8th byte, nothing else. With EMIT_PAUSE = 0, count stays 0.
- DEPTH = 4, five distinct makes (15, 1D, 24, 2D, 2C) with ready = 0: count = 4, overflow = 1, head = 15, and 2C is lost. A push coinciding with a pop while full keeps count = 4 and does not change overflow. Pulsing clr_overflow then gives overflow = 0.
- Feed E0, pulse reset_n low for 1 cycle asynchronously, then byte 74: event {0,1,74}, with no stale ext flag.
